cb: RTL and testbench

Branch transfer-control unit for one stage of the data-driven pipeline. It runs the four-phase request/acknowledge handshake with the upstream stage and issues a one-cycle capture strobe (CP) that loads the stage's data latches. It then routes the request to one of two downstream branches (a or b), chosen by the packet's branch bit BR. The enclosing branch stage owns the data path; cb owns only control.

---
 rtl/cb.sv | 85 ++++++++
 tb/tb_cb.sv | 115 +++++++++++
 2 files changed

// File: rtl/cb.sv
// cb: branch transfer-control unit; four-phase upstream handshake, one-cycle
// capture strobe, and routing of the request to downstream branch a or b.
//
// Ports:
//   CLK            system clock, rising edge
//   MR             master reset, asynchronous, active-low
//   CB_Send_in     upstream request (packet data valid)
//   BR             branch select from the packet, 0 = branch a, 1 = branch b
//   CB_Ack_in_a    acknowledge from branch a
//   CB_Ack_in_b    acknowledge from branch b
//   CB_Ack_out     acknowledge to upstream
//   CB_Send_out_a  request to branch a
//   CB_Send_out_b  request to branch b
//   CB_CP          one-cycle capture pulse for the stage data latches
module cb (
    input  logic CLK,
    input  logic MR,
    input  logic CB_Send_in,
    input  logic BR,
    input  logic CB_Ack_in_a,
    input  logic CB_Ack_in_b,
    output logic CB_Ack_out,
    output logic CB_Send_out_a,
    output logic CB_Send_out_b,
    output logic CB_CP
);

    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, RTZ} state_e;

    state_e state_q, state_d;
    logic   ack_q, ack_d;
    logic   br_q, br_d;
    logic   cp_q, cp_d;
    logic   send_a_q, send_a_d;
    logic   send_b_q, send_b_d;
    logic   accept;
    logic   sel_ack;

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            br_q     <= 1'b0;
            cp_q     <= 1'b0;
            send_a_q <= 1'b0;
            send_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            br_q     <= br_d;
            cp_q     <= cp_d;
            send_a_q <= send_a_d;
            send_b_q <= send_b_d;
        end
    end

    always_comb begin
        // A new token is taken only when upstream has returned to zero, no
        // token is held, and neither branch is still holding its acknowledge.
        accept  = CB_Send_in && !ack_q && (state_q == IDLE) && !CB_Ack_in_a && !CB_Ack_in_b;
        // Only the acknowledge of the branch that owns the token matters.
        sel_ack = br_q ? CB_Ack_in_b : CB_Ack_in_a;
        state_d = state_q;
        case (state_q)
            // The request is raised one cycle after the capture pulse so the
            // captured data is stable before downstream sees it.
            IDLE:    if (cp_q) state_d = br_q ? SEND_B : SEND_A;
            SEND_A:  if (CB_Ack_in_a) state_d = RTZ;
            SEND_B:  if (CB_Ack_in_b) state_d = RTZ;
            RTZ:     if (!sel_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        br_d     = accept ? BR : br_q;
        ack_d    = accept ? 1'b1 : (ack_q && !CB_Send_in) ? 1'b0 : ack_q;
        cp_d     = accept;
        send_a_d = (state_d == SEND_A);
        send_b_d = (state_d == SEND_B);
    end

    assign CB_Ack_out    = ack_q;
    assign CB_Send_out_a = send_a_q;
    assign CB_Send_out_b = send_b_q;
    assign CB_CP         = cp_q;

endmodule

// File: tb/tb_cb.sv
// tb_cb: directed table-driven bench for the cb branch transfer-control unit.
module tb_cb;

    logic CLK, MR, CB_Send_in, BR, CB_Ack_in_a, CB_Ack_in_b;
    logic CB_Ack_out, CB_Send_out_a, CB_Send_out_b, CB_CP;

    int errors = 0;
    int checks = 0;

    cb dut (
        .CLK(CLK),
        .MR(MR),
        .CB_Send_in(CB_Send_in),
        .BR(BR),
        .CB_Ack_in_a(CB_Ack_in_a),
        .CB_Ack_in_b(CB_Ack_in_b),
        .CB_Ack_out(CB_Ack_out),
        .CB_Send_out_a(CB_Send_out_a),
        .CB_Send_out_b(CB_Send_out_b),
        .CB_CP(CB_CP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // in  = {MR, CB_Send_in, BR, CB_Ack_in_a, CB_Ack_in_b}
    // exp = {CB_Ack_out, CB_Send_out_a, CB_Send_out_b, CB_CP}
    typedef struct packed {
        logic [4:0] in;
        logic [3:0] exp;
    } vec_t;

    localparam int NV = 23;
    vec_t v [NV];

    function automatic logic [3:0] outs();
        return {CB_Ack_out, CB_Send_out_a, CB_Send_out_b, CB_CP};
    endfunction

    task automatic check(input string name, input logic [3:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s: got {ack,a,b,cp}=%b expected %b", name, outs(), exp);
        end
    endtask

    task automatic apply(input logic [4:0] in);
        @(negedge CLK);
        {MR, CB_Send_in, BR, CB_Ack_in_a, CB_Ack_in_b} = in;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        {MR, CB_Send_in, BR, CB_Ack_in_a, CB_Ack_in_b} = 5'b01100;
        // reset held with a pending request on branch b
        v[0]  = {5'b01100, 4'b0000};
        v[1]  = {5'b01100, 4'b0000};
        // reset released: request accepted, then routed to b
        v[2]  = {5'b11100, 4'b1001};
        v[3]  = {5'b11100, 4'b1010};
        v[4]  = {5'b10100, 4'b0010};
        v[5]  = {5'b10101, 4'b0000};
        v[6]  = {5'b10100, 4'b0000};
        // branch a full cycle with a wrong-branch acknowledge pulse
        v[7]  = {5'b11000, 4'b1001};
        v[8]  = {5'b11000, 4'b1100};
        v[9]  = {5'b11001, 4'b1100};
        v[10] = {5'b11000, 4'b1100};
        v[11] = {5'b11010, 4'b1000};
        v[12] = {5'b10010, 4'b0000};
        v[13] = {5'b10000, 4'b0000};
        // accept with BR=1, BR flips to 0 afterwards
        v[14] = {5'b11100, 4'b1001};
        v[15] = {5'b11000, 4'b1010};
        v[16] = {5'b10000, 4'b0010};
        // backpressure: second request blocked until branch b finishes
        v[17] = {5'b11000, 4'b0010};
        v[18] = {5'b11000, 4'b0010};
        v[19] = {5'b11001, 4'b0000};
        v[20] = {5'b11000, 4'b0000};
        v[21] = {5'b11000, 4'b1001};
        v[22] = {5'b11000, 4'b1100};

        #2;
        check("reset_async", 4'b0000);
        for (int i = 0; i < NV; i++) begin
            apply(v[i].in);
            check($sformatf("row%0d", i), v[i].exp);
        end

        // mid-transfer reset in SEND_A: outputs drop before any clock edge
        @(negedge CLK);
        MR = 1'b0;
        #1;
        check("midreset_immediate", 4'b0000);
        @(posedge CLK);
        #1;
        check("midreset_held", 4'b0000);
        apply(5'b10000);
        check("post_reset_idle", 4'b0000);
        // acknowledge still high from a branch blocks acceptance
        apply(5'b11010);
        check("ack_in_blocks", 4'b0000);
        apply(5'b11000);
        check("accept_after_block", 4'b1001);
        apply(5'b11000);
        check("send_a_after_block", 4'b1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
